div_frac_seq: RTL

Sequential controller for a 10-bit unsigned divider, computing n/d in bit-serial form. It produces the integer quotient, then FRAC_STAGES groups of three decimal fraction digits (0..999 per group). Each group comes from the remainder scaled by 1000, using one restoring compare/subtract step per cycle. It replaces the combinational cascade where area matters, e.g. pixel-rate scaling setup in the VGA pipeline, and is driven by a start/done handshake.

---
 rtl/div_frac_seq_if.sv | 47 ++++
 rtl/div_frac_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_frac_seq_if.sv
// ============================================================================
//  Module      : div_frac_seq_if
//  Description : Start/done handshake and result bundle for div_frac_seq.
//                The rem signal exists only when DIV_REMAINDER_OUT_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_frac_seq_if #(
   parameter int FRAC_STAGES = 1,
   parameter int W           = 10
) ();

   logic                     start;
   logic [W-1:0]             n;
   logic [W-1:0]             d;
   logic                     busy;
   logic                     done;
   logic                     dz;
   logic [W-1:0]             q;
   logic [W*FRAC_STAGES-1:0] frac;
`ifdef DIV_REMAINDER_OUT_EN
   logic [W-1:0]             rem;
`endif

   // Requester side: drives the operands, observes status and results
   modport master (
      output start, n, d,
      input  busy, done, dz, q, frac
`ifdef DIV_REMAINDER_OUT_EN
      , input rem
`endif
   );

   // Divider side
   modport slave (
      input  start, n, d,
      output busy, done, dz, q, frac
`ifdef DIV_REMAINDER_OUT_EN
      , output rem
`endif
   );

endinterface : div_frac_seq_if

`default_nettype wire

// File: rtl/div_frac_seq.sv
// ============================================================================
//  Module      : div_frac_seq
//  Description : Bit-serial 10-bit unsigned divider. Computes the integer
//                quotient n/d (one restoring step per cycle), then
//                FRAC_STAGES groups of three decimal fraction digits, each
//                obtained by scaling the remainder by 1000 and dividing again.
//                Optional feature macro: DIV_REMAINDER_OUT_EN adds the final
//                remainder output (rem) on the interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_frac_seq #(
   parameter int FRAC_STAGES = 1,
   parameter int W           = 10
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   div_frac_seq_if.slave bus
);

   localparam int              c_FW       = W * FRAC_STAGES;
   localparam int              c_CW       = $clog2(W);
   localparam logic [c_CW-1:0] c_CNT_TOP  = c_CW'(W - 1);
   localparam logic [2:0]      c_LAST_K   = 3'(FRAC_STAGES - 1);
   localparam logic [2*W-1:0]  c_SCALE    = (2*W)'(1000);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INT  = 3'd1,
      S_MUL  = 3'd2,
      S_FRAC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_n;        // dividend, shifted left one bit per INT step
   logic [W-1:0]    r_d;
   logic [2*W-1:0]  r_r;        // running partial remainder
   logic [c_CW-1:0] r_cnt;
   logic [2:0]      r_k;        // fraction group index
   logic            r_busy;
   logic            r_done;
   logic            r_dz;
   logic [W-1:0]    r_q;
   logic [c_FW-1:0] r_frac;

   logic [2*W-1:0]  w_d_ext;
   logic [2*W-1:0]  w_t;
   logic            w_t_ge;
   logic [2*W-1:0]  w_d_sh;
   logic            w_f_ge;
   logic [2*W-1:0]  w_mul;

   // Datapath for one restoring step in INT (shift in next dividend bit)
   // and FRAC (compare against the divisor aligned to the current bit).
   // The FRAC quotient never exceeds 999, so d<<cnt always fits in 2*W bits.
   always_comb begin
      w_d_ext = {{W{1'b0}}, r_d};
      w_t     = {r_r[2*W-2:0], r_n[W-1]};
      w_t_ge  = (w_t >= w_d_ext);
      w_d_sh  = w_d_ext << r_cnt;
      w_f_ge  = (r_r >= w_d_sh);
      w_mul   = r_r * c_SCALE;
   end

   // Control FSM and result registers; q and frac fill MSB first by shifting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_d     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
         r_q     <= '0;
         r_frac  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_n    <= bus.n;
                  r_d    <= bus.d;
                  r_q    <= '0;
                  r_frac <= '0;
                  r_r    <= '0;
                  r_cnt  <= c_CNT_TOP;
                  r_k    <= '0;
                  if (bus.d == '0) begin
                     r_dz    <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_dz    <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_INT;
                  end
               end
            end

            S_INT: begin
               r_r <= w_t_ge ? (w_t - w_d_ext) : w_t;
               r_q <= {r_q[W-2:0], w_t_ge};
               r_n <= {r_n[W-2:0], 1'b0};
               if (r_cnt == '0) begin
                  r_state <= S_MUL;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_MUL: begin
               // r < d <= 1023, so r*1000 stays below 2^20
               r_r     <= w_mul;
               r_cnt   <= c_CNT_TOP;
               r_state <= S_FRAC;
            end

            S_FRAC: begin
               r_r    <= w_f_ge ? (r_r - w_d_sh) : r_r;
               r_frac <= {r_frac[c_FW-2:0], w_f_ge};
               if (r_cnt == '0) begin
                  if (r_k == c_LAST_K) begin
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_k     <= r_k + 3'd1;
                     r_state <= S_MUL;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.dz   = r_dz;
   assign bus.q    = r_q;
   assign bus.frac = r_frac;

`ifdef DIV_REMAINDER_OUT_EN
   // The remainder register is untouched between DONE and the next accept
   // and is cleared on accept, so it already holds and reads 0 for dz.
   assign bus.rem  = r_r[W-1:0];
`endif

endmodule : div_frac_seq

`default_nettype wire
